// File: rtl/lock_pkg.sv
// Shared types and helpers for the lock-picking level.
// Default screen geometry lives here so callers agree on it.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    WIN,
    FAIL
  } lock_state_t;

  localparam int unsigned DEF_Y_TOP   = 32;
  localparam int unsigned DEF_SLOT_H  = 28;
  localparam int unsigned DEF_X_LIMIT = 500;

  function automatic int unsigned slot_dist(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/lock_slot_decoder.sv
// Maps the pick's Y pixel to a vertical slot, one cycle late.
// Off-range Y keeps the last slot but drops slot_valid.
module lock_slot_decoder
  import lock_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned SLOT_H    = DEF_SLOT_H,
  parameter int unsigned Y_TOP     = DEF_Y_TOP,
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pick_y,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              slot_valid
);

  localparam int unsigned Y_BOT = Y_TOP + NUM_SLOTS * SLOT_H - 1;

  logic [31:0] y;
  logic        in_range;

  assign y        = 32'(pick_y);
  assign in_range = (y >= Y_TOP) && (y <= Y_BOT);

  // Register the slot row; hold it while the pick is off the grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_idx   <= '0;
      slot_valid <= 1'b0;
    end else begin
      slot_valid <= in_range;
      if (in_range) begin
        slot_idx <= SLOT_W'((y - Y_TOP) / SLOT_H);
      end
    end
  end

endmodule

// File: rtl/lock_level_multi.sv
// Multi-pin lock-picking level: slot decode, pin sequencing,
// distinct wrong-guess counting, close hint and HUD status.
module lock_level_multi
  import lock_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 16,
  parameter int unsigned SLOT_H      = DEF_SLOT_H,
  parameter int unsigned Y_TOP       = DEF_Y_TOP,
  parameter int unsigned NUM_PINS    = 3,
  parameter int unsigned MAX_GUESSES = 6,
  parameter int unsigned CLOSE_DIST  = 1,
  parameter int unsigned X_LIMIT     = DEF_X_LIMIT,
  localparam int unsigned SLOT_W  = $clog2(NUM_SLOTS),
  localparam int unsigned PIN_W   =
    (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1,
  localparam int unsigned GUESS_W = $clog2(MAX_GUESSES + 1)
) (
  input  logic                       Clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [9:0]                 pick_y,
  input  logic [9:0]                 pick_x,
  input  logic                       commit,
  input  logic                       close_en,
  input  logic [NUM_PINS*SLOT_W-1:0] target_slots,
  output logic [SLOT_W-1:0]          slot_idx,
  output logic [PIN_W-1:0]           pin_idx,
  output logic [NUM_PINS-1:0]        pin_set,
  output logic [GUESS_W-1:0]         guesses,
  output logic                       close,
  output logic                       busy,
  output logic                       done,
  output logic                       failed
);

  lock_state_t state;

  logic                             slot_valid;
  logic                             commit_q;
  logic [NUM_SLOTS-1:0]             seen;
  logic [NUM_PINS-1:0][SLOT_W-1:0]  tgt;
  logic [SLOT_W-1:0]                cur_tgt;
  logic                             attempt;
  logic                             hit;
  logic                             last;
  logic [GUESS_W-1:0]               g_next;

  lock_slot_decoder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_H    (SLOT_H),
    .Y_TOP     (Y_TOP)
  ) u_dec (
    .clk        (Clk),
    .rst_n      (reset_n),
    .pick_y     (pick_y),
    .slot_idx   (slot_idx),
    .slot_valid (slot_valid)
  );

  assign cur_tgt = tgt[pin_idx];
  assign hit     = (slot_idx == cur_tgt);
  assign last    = (32'(pin_idx) == NUM_PINS - 1);
  assign g_next  = guesses + GUESS_W'(1);

  // Only a fresh commit edge on a valid, in-reach slot counts.
  assign attempt = commit & ~commit_q & (state == PLAY)
                 & slot_valid & (32'(pick_x) <= X_LIMIT);

  assign close = (state == PLAY) & close_en & slot_valid & ~hit
               & (slot_dist(32'(slot_idx), 32'(cur_tgt))
                  <= CLOSE_DIST);

  assign busy   = (state == PLAY);
  assign done   = (state == WIN);
  assign failed = (state == FAIL);

  // Level FSM with pin progress, guess counter and dedupe map.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      commit_q <= 1'b0;
      pin_idx  <= '0;
      pin_set  <= '0;
      guesses  <= '0;
      seen     <= '0;
      tgt      <= '0;
    end else begin
      commit_q <= commit;
      if (abort) begin
        state <= IDLE;
      end else if (start) begin
        state   <= PLAY;
        tgt     <= target_slots;
        pin_idx <= '0;
        pin_set <= '0;
        guesses <= '0;
        seen    <= '0;
      end else if (attempt) begin
        if (hit) begin
          pin_set[pin_idx] <= 1'b1;
          seen             <= '0;
          if (last) begin
            state <= WIN;
          end else begin
            pin_idx <= pin_idx + PIN_W'(1);
          end
        end else if (!seen[slot_idx]) begin
          seen[slot_idx] <= 1'b1;
          if (32'(guesses) < MAX_GUESSES) begin
            guesses <= g_next;
          end
          if (32'(g_next) >= MAX_GUESSES) begin
            state <= FAIL;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lock_level_multi.sv
// Bench for lock_level_multi: directed vectors plus a
// rule-level model compared on every falling clock edge.
module tb_lock_level_multi;

  localparam int S_IDLE = 0;
  localparam int S_PLAY = 1;
  localparam int S_WIN  = 2;
  localparam int S_LOST = 3;

  logic        Clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [9:0]  pick_y;
  logic [9:0]  pick_x;
  logic        commit;
  logic        close_en;
  logic [11:0] target_slots;
  logic [3:0]  slot_idx;
  logic [1:0]  pin_idx;
  logic [2:0]  pin_set;
  logic [2:0]  guesses;
  logic        close;
  logic        busy;
  logic        done;
  logic        failed;

  int n_chk  = 0;
  int n_fail = 0;

  lock_level_multi dut (
    .Clk          (Clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .pick_y       (pick_y),
    .pick_x       (pick_x),
    .commit       (commit),
    .close_en     (close_en),
    .target_slots (target_slots),
    .slot_idx     (slot_idx),
    .pin_idx      (pin_idx),
    .pin_set      (pin_set),
    .guesses      (guesses),
    .close        (close),
    .busy         (busy),
    .done         (done),
    .failed       (failed)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model of the level rules.
  int m_st    = 0;
  int m_slot  = 0;
  bit m_valid = 0;
  bit m_cq    = 0;
  int m_pin   = 0;
  int m_set   = 0;
  int m_g     = 0;
  int m_tgt[3];
  bit m_seen[int];
  bit m_att;
  int m_y;

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st = S_IDLE; m_slot = 0; m_valid = 0; m_cq = 0;
      m_pin = 0; m_set = 0; m_g = 0;
      m_seen.delete();
      for (int k = 0; k < 3; k++) m_tgt[k] = 0;
    end else begin
      m_att = commit && !m_cq && m_st == S_PLAY
           && m_valid && int'(pick_x) <= 500;
      if (abort) begin
        m_st = S_IDLE;
      end else if (start) begin
        m_st = S_PLAY; m_pin = 0; m_set = 0; m_g = 0;
        m_seen.delete();
        for (int k = 0; k < 3; k++)
          m_tgt[k] = int'((target_slots >> (4 * k)) & 12'hF);
      end else if (m_att) begin
        if (m_slot == m_tgt[m_pin]) begin
          m_set = m_set | (1 << m_pin);
          m_seen.delete();
          if (m_pin == 2) m_st = S_WIN;
          else m_pin++;
        end else if (!m_seen.exists(m_slot)) begin
          m_seen[m_slot] = 1;
          m_g++;
          if (m_g >= 6) m_st = S_LOST;
        end
      end
      m_cq = commit;
      m_y = int'(pick_y);
      if (m_y >= 32 && m_y <= 32 + 16 * 28 - 1) begin
        m_slot  = (m_y - 32) / 28;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
  end

  int  c_d;
  bit  c_close;

  // Compare every DUT output against the model.
  always @(negedge Clk) begin
    c_d = m_slot - m_tgt[m_pin];
    if (c_d < 0) c_d = -c_d;
    c_close = m_st == S_PLAY && close_en && m_valid
           && c_d != 0 && c_d <= 1;
    chk("m_slot", int'(slot_idx), m_slot);
    chk("m_pin", int'(pin_idx), m_pin);
    chk("m_set", int'(pin_set), m_set);
    chk("m_guess", int'(guesses), m_g);
    chk("m_close", int'(close), int'(c_close));
    chk("m_busy", int'(busy), int'(m_st == S_PLAY));
    chk("m_done", int'(done), int'(m_st == S_WIN));
    chk("m_failed", int'(failed), int'(m_st == S_LOST));
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic go_slot(input int s);
    pick_y = 10'(32 + s * 28 + 3);
    tick();
  endtask

  task automatic hit_once();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int wr[6] = '{3, 3, 7, 8, 9, 10};

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    pick_y = '0; pick_x = 10'd400; commit = 1'b0;
    close_en = 1'b1;
    target_slots = {4'd15, 4'd0, 4'd5};
    tick();
    chk("rst_slot", int'(slot_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_set", int'(pin_set), 0);
    chk("rst_guess", int'(guesses), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_failed", int'(failed), 0);
    reset_n = 1'b1;

    pick_y = 10'd31;  tick(); chk("dec31", int'(slot_idx), 0);
    pick_y = 10'd171;
    chk("dec_lat", int'(slot_idx), 0);
    tick(); chk("dec171", int'(slot_idx), 4);
    pick_y = 10'd32;  tick(); chk("dec32", int'(slot_idx), 0);
    pick_y = 10'd172; tick(); chk("dec172", int'(slot_idx), 5);
    pick_y = 10'd479; tick(); chk("dec479", int'(slot_idx), 15);
    pick_y = 10'd480; tick(); chk("dec480", int'(slot_idx), 15);

    do_start();
    chk("win_busy", int'(busy), 1);
    go_slot(5);  hit_once(); chk("win_p0", int'(pin_set), 1);
    go_slot(0);  hit_once(); chk("win_p1", int'(pin_set), 3);
    go_slot(15);
    commit = 1'b1; tick();
    chk("win_done", int'(done), 1);
    chk("win_p2", int'(pin_set), 7);
    commit = 1'b0; tick();
    chk("win_guess", int'(guesses), 0);

    do_start();
    go_slot(4); chk("cl_s4", int'(close), 1);
    go_slot(6); chk("cl_s6", int'(close), 1);
    go_slot(5); chk("cl_s5", int'(close), 0);
    go_slot(3); chk("cl_s3", int'(close), 0);
    go_slot(4); close_en = 1'b0; #1;
    chk("cl_dis", int'(close), 0);
    close_en = 1'b1;
    go_slot(5); hit_once(); chk("cl_pin1", int'(pin_idx), 1);
    go_slot(15); chk("cl_wrap", int'(close), 0);
    go_slot(1);  chk("cl_s1", int'(close), 1);

    do_start();
    go_slot(3);
    commit = 1'b1;
    repeat (10) tick();
    commit = 1'b0; tick();
    chk("q_hold", int'(guesses), 1);
    pick_x = 10'd501;
    go_slot(5); hit_once();
    chk("q_xlim", int'(pin_set), 0);
    pick_x = 10'd400;
    pick_y = 10'd480; tick(); hit_once();
    chk("q_inv_g", int'(guesses), 1);
    chk("q_inv_s", int'(pin_set), 0);
    go_slot(5);
    commit = 1'b1; start = 1'b1; tick();
    start = 1'b0; commit = 1'b0; tick();
    chk("q_start_s", int'(pin_set), 0);
    chk("q_start_g", int'(guesses), 0);

    do_start();
    foreach (wr[i]) begin
      go_slot(wr[i]); hit_once();
    end
    chk("f_g5", int'(guesses), 5);
    chk("f_busy", int'(busy), 1);
    go_slot(11); hit_once();
    chk("f_g6", int'(guesses), 6);
    chk("f_failed", int'(failed), 1);
    go_slot(12); hit_once();
    chk("f_hold", int'(guesses), 6);
    go_slot(5); hit_once();
    chk("f_noset", int'(pin_set), 0);

    do_start();
    go_slot(1); hit_once();
    go_slot(2); hit_once();
    chk("ab_g2", int'(guesses), 2);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    do_start();
    chk("ab_g0", int'(guesses), 0);
    chk("ab_set0", int'(pin_set), 0);
    chk("ab_busy1", int'(busy), 1);

    go_slot(5); hit_once();
    chk("ar_set", int'(pin_set), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_set0", int'(pin_set), 0);
    chk("ar_pin0", int'(pin_idx), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_slot", int'(slot_idx), 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
